// File: rtl/csr_exec.sv
// Zicsr execution sequencer: reads a CSR, computes the RW/RS/RC update, strobes
// the write, and returns the old value for rd. Optional macro: CSR_EXEC_RO_CHECK_EN.
module csr_exec #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rs1_idx,
  input  logic [4:0]      req_rd_idx,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      resp_rd_idx,
  output logic            resp_rd_wen,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  output logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_wen,
  output logic [XLEN-1:0] csr_wdata
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // READ  | CSR file addressed, old value and update computed
  // WRITE | single-cycle write strobe to the CSR file
  // RESP  | old value presented until resp_ready
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t state, state_nxt;

  // funct3[2] only selects the operand source, so just the op bits are kept.
  logic [1:0]      op_q;
  logic [11:0]     addr_q;
  logic [4:0]      rd_idx_q;
  logic [XLEN-1:0] operand_q;
  logic            src_zero_q;
  logic [XLEN-1:0] old_val_q;
  logic [XLEN-1:0] new_val_q;
  logic            illegal_q;

  logic [XLEN-1:0] new_val;
  logic            rsvd;
  logic            do_write;
  logic            ro_fault;
  logic            write_ok;

  always_comb begin
    rsvd     = (op_q == 2'b00);
    do_write = ~rsvd & ((op_q == 2'b01) | ~src_zero_q);
    case (op_q)
      2'b01:   new_val = operand_q;
      2'b10:   new_val = csr_rdata | operand_q;
      2'b11:   new_val = csr_rdata & ~operand_q;
      default: new_val = csr_rdata;
    endcase
`ifdef CSR_EXEC_RO_CHECK_EN
    ro_fault = do_write & (addr_q[11:10] == 2'b11);
`else
    ro_fault = 1'b0;
`endif
    write_ok = do_write & ~ro_fault;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = READ;
      READ:    state_nxt = write_ok ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      addr_q     <= '0;
      rd_idx_q   <= '0;
      operand_q  <= '0;
      src_zero_q <= 1'b0;
      old_val_q  <= '0;
      new_val_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q       <= req_funct3[1:0];
        addr_q     <= req_addr;
        rd_idx_q   <= req_rd_idx;
        operand_q  <= req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_val;
        src_zero_q <= (req_rs1_idx == 5'd0);
      end
      if (state == READ) begin
        old_val_q <= csr_rdata;
        new_val_q <= new_val;
        illegal_q <= rsvd | ro_fault;
      end
    end
  end

  always_comb begin
    req_ready    = (state == IDLE);
    resp_valid   = (state == RESP);
    csr_wen      = (state == WRITE);
    resp_rd_wen  = (state == RESP) & (rd_idx_q != 5'd0) & ~illegal_q;
    resp_rd_idx  = rd_idx_q;
    resp_rdata   = old_val_q;
    resp_illegal = illegal_q;
    csr_addr     = addr_q;
    csr_wdata    = new_val_q;
  end

endmodule

// File: tb/tb_csr_exec.sv
// Directed self-checking bench for csr_exec; expectations are hand-computed per vector.
module tb_csr_exec;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rs1_idx;
  logic [4:0]  req_rd_idx;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd_idx;
  logic        resp_rd_wen;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [31:0] csr_wdata;

  int n_cmp = 0;
  int n_err = 0;

  // result of the most recent run_op
  int          r_lat;
  int          r_wen_cnt;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [4:0]  r_rd_idx;
  logic        r_rd_wen;
  logic        r_illegal;

  always #5 clock = ~clock;

  csr_exec #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_val(req_rs1_val), .req_rs1_idx(req_rs1_idx),
    .req_rd_idx(req_rd_idx),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_idx(resp_rd_idx),
    .resp_rd_wen(resp_rd_wen), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_wen(csr_wen), .csr_wdata(csr_wdata)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1v, input logic [4:0] rs1i,
                        input logic [4:0] rd, input logic [31:0] old);
    csr_rdata   = old;
    resp_ready  = 1'b1;
    req_valid   = 1'b1;
    req_funct3  = f3;
    req_addr    = addr;
    req_rs1_val = rs1v;
    req_rs1_idx = rs1i;
    req_rd_idx  = rd;
    r_lat = 0; r_wen_cnt = 0; r_wdata = '0;
    r_rdata = '0; r_rd_idx = '0; r_rd_wen = 1'b0; r_illegal = 1'b0;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (csr_wen) begin
        r_wen_cnt++;
        r_wdata = csr_wdata;
      end
      if (resp_valid) begin
        r_lat     = k;
        r_rdata   = resp_rdata;
        r_rd_idx  = resp_rd_idx;
        r_rd_wen  = resp_rd_wen;
        r_illegal = resp_illegal;
        step();
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; csr_rdata = '0;
    req_funct3 = '0; req_addr = '0; req_rs1_val = '0; req_rs1_idx = '0; req_rd_idx = '0;
    step(); step();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if (csr_wen !== 1'b0) begin n_err++; $display("FAIL rst_csr_wen got %b want 0", csr_wen); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
    n_cmp++; if ({resp_rd_wen, resp_illegal} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b want 00", {resp_rd_wen, resp_illegal}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_rs_no_write();
    run_op(3'b010, 12'hB00, 32'hDEAD_BEEF, 5'd0, 5'd5, 32'h0000_1234);
    n_cmp++; if (r_lat !== 2) begin n_err++; $display("FAIL rs0_latency got %0d want 2", r_lat); end
    n_cmp++; if (r_wen_cnt !== 0) begin n_err++; $display("FAIL rs0_wen_count got %0d want 0", r_wen_cnt); end
    n_cmp++; if (r_rdata !== 32'h0000_1234) begin n_err++; $display("FAIL rs0_rdata got %h want 00001234", r_rdata); end
    n_cmp++; if (r_rd_idx !== 5'd5) begin n_err++; $display("FAIL rs0_rd_idx got %0d want 5", r_rd_idx); end
    n_cmp++; if ({r_rd_wen, r_illegal} !== 2'b10) begin n_err++; $display("FAIL rs0_rd_wen_illegal got %b want 10", {r_rd_wen, r_illegal}); end
  endtask

  task automatic test_rc_write();
    run_op(3'b011, 12'h301, 32'h0000_0010, 5'd3, 5'd7, 32'h4000_0010);
    n_cmp++; if (r_lat !== 3) begin n_err++; $display("FAIL rc_latency got %0d want 3", r_lat); end
    n_cmp++; if (r_wen_cnt !== 1) begin n_err++; $display("FAIL rc_wen_count got %0d want 1", r_wen_cnt); end
    n_cmp++; if (r_wdata !== 32'h4000_0000) begin n_err++; $display("FAIL rc_wdata got %h want 40000000", r_wdata); end
    n_cmp++; if (r_rdata !== 32'h4000_0010) begin n_err++; $display("FAIL rc_rdata got %h want 40000010", r_rdata); end
  endtask

  task automatic test_imm_forms();
    // uimm is zero-extended even though rs1_val is all ones
    run_op(3'b101, 12'h340, 32'hFFFF_FFFF, 5'h1F, 5'd0, 32'hFFFF_FFFF);
    n_cmp++; if (r_wdata !== 32'h0000_001F) begin n_err++; $display("FAIL rwi_wdata got %h want 0000001f", r_wdata); end
    n_cmp++; if (r_rd_wen !== 1'b0) begin n_err++; $display("FAIL rwi_rd_wen got %b want 0", r_rd_wen); end
    n_cmp++; if (r_lat !== 3) begin n_err++; $display("FAIL rwi_latency got %0d want 3", r_lat); end
    run_op(3'b111, 12'h300, 32'h0, 5'h05, 5'd9, 32'h0000_000F);
    n_cmp++; if (r_wdata !== 32'h0000_000A) begin n_err++; $display("FAIL rci_wdata got %h want 0000000a", r_wdata); end
    run_op(3'b110, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd9, 32'h0000_0077);
    n_cmp++; if (r_wen_cnt !== 0) begin n_err++; $display("FAIL rsi0_wen_count got %0d want 0", r_wen_cnt); end
    n_cmp++; if (r_lat !== 2) begin n_err++; $display("FAIL rsi0_latency got %0d want 2", r_lat); end
  endtask

  task automatic test_rw_rs_vals();
    run_op(3'b010, 12'h305, 32'h0000_00F0, 5'd2, 5'd1, 32'h0000_0F00);
    n_cmp++; if (r_wdata !== 32'h0000_0FF0) begin n_err++; $display("FAIL rs_wdata got %h want 00000ff0", r_wdata); end
    // RW with x0 source still writes
    run_op(3'b001, 12'h305, 32'hA5A5_A5A5, 5'd0, 5'd4, 32'h1111_2222);
    n_cmp++; if (r_wen_cnt !== 1) begin n_err++; $display("FAIL rw_x0_wen_count got %0d want 1", r_wen_cnt); end
    n_cmp++; if (r_wdata !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL rw_x0_wdata got %h want a5a5a5a5", r_wdata); end
    n_cmp++; if (r_rdata !== 32'h1111_2222) begin n_err++; $display("FAIL rw_x0_rdata got %h want 11112222", r_rdata); end
  endtask

  task automatic test_reserved();
    run_op(3'b100, 12'h300, 32'h1, 5'd1, 5'd3, 32'h0000_5555);
    n_cmp++; if (r_illegal !== 1'b1) begin n_err++; $display("FAIL rsvd_illegal got %b want 1", r_illegal); end
    n_cmp++; if (r_wen_cnt !== 0) begin n_err++; $display("FAIL rsvd_wen_count got %0d want 0", r_wen_cnt); end
    n_cmp++; if (r_rd_wen !== 1'b0) begin n_err++; $display("FAIL rsvd_rd_wen got %b want 0", r_rd_wen); end
    n_cmp++; if (r_lat !== 2) begin n_err++; $display("FAIL rsvd_latency got %0d want 2", r_lat); end
    // a legal op right after clears the illegal flag
    run_op(3'b010, 12'h300, 32'h0, 5'd0, 5'd3, 32'h0000_0001);
    n_cmp++; if (r_illegal !== 1'b0) begin n_err++; $display("FAIL post_rsvd_illegal got %b want 0", r_illegal); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] h_rdata;
    logic [4:0]  h_idx;
    logic [2:0]  h_flags;
    int          waited;
    csr_rdata = 32'hCAFE_0001;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 12'hC00;
    req_rs1_val = '0; req_rs1_idx = 5'd0; req_rd_idx = 5'd12;
    step();
    req_valid = 1'b0;
    waited = 0;
    while (!resp_valid && waited < 10) begin step(); waited++; end
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_resp_timeout got %b want 1", resp_valid); end
    h_rdata = resp_rdata; h_idx = resp_rd_idx; h_flags = {resp_valid, resp_rd_wen, resp_illegal};
    n_cmp++; if (h_rdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL bp_rdata got %h want cafe0001", h_rdata); end
    csr_rdata = 32'h0BAD_0BAD;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if ({resp_valid, resp_rd_wen, resp_illegal} !== 3'b110 || resp_rdata !== h_rdata
          || resp_rd_idx !== h_idx || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d got v/w/i=%b rdata=%h idx=%0d req_ready=%b want 110 %h %0d 0",
                 k, {resp_valid, resp_rd_wen, resp_illegal}, resp_rdata, resp_rd_idx, req_ready, h_rdata, h_idx);
      end
    end
    resp_ready = 1'b1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready_same_cycle got %b want 0", req_ready); end
    step();
    n_cmp++; if ({req_ready, resp_valid} !== 2'b10) begin n_err++; $display("FAIL bp_after_hs got %b want 10", {req_ready, resp_valid}); end
  endtask

  task automatic test_reset_mid_op();
    int wen_seen;
    wen_seen = 0;
    csr_rdata = 32'h1;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h340;
    req_rs1_val = 32'h1234_5678; req_rs1_idx = 5'd8; req_rd_idx = 5'd2;
    step();
    req_valid = 1'b0;
    // now in READ
    reset = 1'b1;
    #1;
    if (csr_wen) wen_seen++;
    n_cmp++; if ({req_ready, resp_valid} !== 2'b10) begin n_err++; $display("FAIL rst_mid_async got %b want 10", {req_ready, resp_valid}); end
    step();
    if (csr_wen) wen_seen++;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (csr_wen) wen_seen++;
    end
    n_cmp++; if (wen_seen !== 0) begin n_err++; $display("FAIL rst_mid_wen_count got %0d want 0", wen_seen); end
    n_cmp++; if ({req_ready, resp_valid} !== 2'b10) begin n_err++; $display("FAIL rst_mid_after got %b want 10", {req_ready, resp_valid}); end
  endtask

  task automatic test_ro_check();
    run_op(3'b001, 12'hF11, 32'h0000_00AA, 5'd6, 5'd10, 32'h0000_0600);
`ifdef CSR_EXEC_RO_CHECK_EN
    n_cmp++; if (r_illegal !== 1'b1) begin n_err++; $display("FAIL ro_illegal got %b want 1", r_illegal); end
    n_cmp++; if (r_wen_cnt !== 0) begin n_err++; $display("FAIL ro_wen_count got %0d want 0", r_wen_cnt); end
    n_cmp++; if (r_rd_wen !== 1'b0) begin n_err++; $display("FAIL ro_rd_wen got %b want 0", r_rd_wen); end
`else
    n_cmp++; if (r_illegal !== 1'b0) begin n_err++; $display("FAIL ro_illegal got %b want 0", r_illegal); end
    n_cmp++; if (r_wen_cnt !== 1) begin n_err++; $display("FAIL ro_wen_count got %0d want 1", r_wen_cnt); end
    n_cmp++; if (r_wdata !== 32'h0000_00AA) begin n_err++; $display("FAIL ro_wdata got %h want 000000aa", r_wdata); end
`endif
    // reading a read-only CSR without writing is always legal
    run_op(3'b010, 12'hF11, 32'h0, 5'd0, 5'd10, 32'h0000_0600);
    n_cmp++; if ({r_illegal, r_rd_wen} !== 2'b01) begin n_err++; $display("FAIL ro_read got %b want 01", {r_illegal, r_rd_wen}); end
    n_cmp++; if (r_rdata !== 32'h0000_0600) begin n_err++; $display("FAIL ro_read_rdata got %h want 00000600", r_rdata); end
  endtask

  initial begin
    test_reset();
    test_rs_no_write();
    test_rc_write();
    test_imm_forms();
    test_rw_rs_vals();
    test_reserved();
    test_back_pressure();
    test_reset_mid_op();
    test_ro_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
